// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix keypad scan, debounce and one-entry key-code holding register.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int ROWS         = 4,
  parameter int COLS         = 3,
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 8,
  parameter int REPEAT_DLY   = 64,
  parameter int REPEAT_RATE  = 16,
  localparam int CODE_W      = $clog2(ROWS*COLS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [COLS-1:0]   i_col,
  input  logic              i_key_ack,
  output logic [ROWS-1:0]   o_row,
  output logic [CODE_W-1:0] o_key_code,
  output logic              o_key_valid,
  output logic              o_press,
  output logic              o_overrun
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam int RL = (DEBOUNCE_CNT > 1) ? DEBOUNCE_CNT - 2 : 0;

  localparam logic [SW-1:0] DWELL_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CNT - 1);
  localparam logic [DW-1:0] REL_LAST   = DW'(RL);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_HELD,
    S_RELEASE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [RW-1:0]     r_row, w_row_nxt, w_row_inc;
  logic [SW-1:0]     r_dwell, w_dwell_nxt;
  logic [CW-1:0]     r_col, w_col_nxt, w_col_lo;
  logic [DW-1:0]     r_cnt, w_cnt_nxt;
  logic [CODE_W-1:0] r_code, w_code;
  logic              r_valid;
  logic              r_ovr;
  logic              w_col_any;
  logic              w_hit;
  logic              w_load;
  logic              w_rep_clr;
  logic              w_rep_fire;

  always_comb begin
    w_col_lo = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (i_col[i]) w_col_lo = CW'(i);
    end
  end

  assign w_col_any = |i_col;
  assign w_hit     = i_col[r_col];
  assign w_row_inc = (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
  assign w_code    = CODE_W'(int'(r_row) * COLS + int'(r_col));

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_dwell_nxt = r_dwell;
    w_col_nxt   = r_col;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_rep_clr   = 1'b0;
    unique case (r_state)
      S_SCAN: begin
        if (r_dwell == DWELL_LAST) begin
          w_dwell_nxt = '0;
          if (w_col_any) begin
            w_state_nxt = S_DEBOUNCE;
            w_col_nxt   = w_col_lo;
            w_cnt_nxt   = '0;
          end else begin
            w_row_nxt = w_row_inc;
          end
        end else begin
          w_dwell_nxt = r_dwell + 1'b1;
        end
      end
      S_DEBOUNCE: begin
        if (!w_hit) begin
          w_state_nxt = S_SCAN;
          w_row_nxt   = w_row_inc;
          w_dwell_nxt = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = S_HELD;
          w_load      = 1'b1;
          w_rep_clr   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_HELD: begin
        // the first low cycle already counts toward the release window
        if (!w_hit) begin
          if (DEBOUNCE_CNT == 1) begin
            w_state_nxt = S_SCAN;
            w_row_nxt   = w_row_inc;
            w_dwell_nxt = '0;
          end else begin
            w_state_nxt = S_RELEASE;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_load = w_rep_fire;
        end
      end
      S_RELEASE: begin
        if (w_hit) begin
          w_state_nxt = S_HELD;
          w_cnt_nxt   = '0;
          w_rep_clr   = 1'b1;
        end else if (r_cnt == REL_LAST) begin
          w_state_nxt = S_SCAN;
          w_row_nxt   = w_row_inc;
          w_dwell_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_SCAN;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_SCAN;
      r_row   <= '0;
      r_dwell <= '0;
      r_col   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_dwell <= w_dwell_nxt;
      r_col   <= w_col_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // a load on the ack edge wins: valid stays set and no overrun
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_code  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_load) begin
        r_code  <= w_code;
        r_valid <= 1'b1;
        r_ovr   <= r_valid & ~i_key_ack;
      end else if (i_key_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int PW   = $clog2(RMAX + 1);

  logic [PW-1:0] r_rep_cnt, w_rep_last;
  logic          r_rep_first;

  assign w_rep_last = r_rep_first ? PW'(REPEAT_DLY - 1)
                                  : PW'(REPEAT_RATE - 1);
  assign w_rep_fire = (r_state == S_HELD) && (r_rep_cnt == w_rep_last);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if (w_rep_clr) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if (r_state == S_HELD) begin
      if (w_rep_fire) begin
        r_rep_cnt   <= '0;
        r_rep_first <= 1'b0;
      end else begin
        r_rep_cnt <= r_rep_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_rep;

  assign w_rep_fire = 1'b0;
  assign unused_rep = w_rep_clr ^ (REPEAT_DLY == REPEAT_RATE);
`endif

  assign o_row       = ROWS'(1) << r_row;
  assign o_key_code  = r_code;
  assign o_key_valid = r_valid;
  assign o_press     = (r_state == S_HELD) || (r_state == S_RELEASE);
  assign o_overrun   = r_ovr;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad presses checked against a timeline model of scan/debounce.
// Works with or without KEYPAD_REPEAT_EN defined.
module tb_keypad_scanner;

  localparam int ROWS   = 4;
  localparam int COLS   = 3;
  localparam int SD     = 4;
  localparam int DB     = 8;
  localparam int DLY    = 64;
  localparam int RATE   = 16;
  localparam int CODE_W = $clog2(ROWS*COLS);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ack = 1'b0;
  logic [COLS-1:0]   col = '0;
  logic [ROWS-1:0]   row;
  logic [CODE_W-1:0] code;
  logic              valid;
  logic              press;
  logic              ovr;

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE_CNT(DB),
    .REPEAT_DLY(DLY), .REPEAT_RATE(RATE)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_col(col), .i_key_ack(ack),
    .o_row(row), .o_key_code(code), .o_key_valid(valid),
    .o_press(press), .o_overrun(ovr)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // scan timeline: after edge base_ec the scanner sits on base_row, dwell 0
  int ec       = 0;
  int base_ec  = 0;
  int base_row = 0;

  // keypad: key mask kmask on row kr is down
  logic            down  = 1'b0;
  int              kr    = 0;
  logic [COLS-1:0] kmask = '0;

  // holding register model
  logic ld_next = 1'b0;
  int   ld_code = 0;
  logic m_valid = 1'b0;
  logic m_ovr   = 1'b0;
  int   m_code  = 0;

  function automatic int scan_row();
    return (base_row + (ec - base_ec) / SD) % ROWS;
  endfunction

  function automatic logic [ROWS-1:0] oh(int r);
    return ROWS'(1) << r;
  endfunction

  task automatic drive_col();
    col = (down && row[kr]) ? kmask : '0;
  endtask

  task automatic step();
    @(posedge clk);
    if (ld_next) begin
      m_ovr   = m_valid && !ack;
      m_valid = 1'b1;
      m_code  = ld_code;
    end else begin
      m_ovr = 1'b0;
      if (ack) m_valid = 1'b0;
    end
    ld_next = 1'b0;
    #1;
    ec++;
    drive_col();
  endtask

  task automatic chk(string tag, int er, logic ep);
    logic [ROWS-1:0] erv;
    erv = oh(er);
    n_assert++;
    assert (row === erv) else begin
      n_fail++;
      $error("FAIL %s row got %b exp %b", tag, row, erv);
    end
    n_assert++;
    assert (press === ep) else begin
      n_fail++;
      $error("FAIL %s press got %b exp %b", tag, press, ep);
    end
    n_assert++;
    assert (valid === m_valid) else begin
      n_fail++;
      $error("FAIL %s valid got %b exp %b", tag, valid, m_valid);
    end
    n_assert++;
    assert (ovr === m_ovr) else begin
      n_fail++;
      $error("FAIL %s overrun got %b exp %b", tag, ovr, m_ovr);
    end
    n_assert++;
    assert (code === CODE_W'(m_code)) else begin
      n_fail++;
      $error("FAIL %s code got %0d exp %0d", tag, code, m_code);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      step();
      chk("idle", scan_row(), 1'b0);
    end
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ack", scan_row(), 1'b0);
  endtask

  // step until the edge that samples row r, then take that edge
  task automatic to_sample(int r);
    for (int i = 0; i < ROWS * SD; i++) begin
      if (((ec - base_ec) % SD == SD - 1) && scan_row() == r) break;
      step();
      chk("scan", scan_row(), 1'b0);
    end
    step();
    chk("sample", r, 1'b0);
  endtask

  task automatic press_key(int r, logic [COLS-1:0] cm, int hold,
                           int ackd, bit do_rst);
    int c;
    int since;
    c = 0;
    for (int i = COLS - 1; i >= 0; i--) if (cm[i]) c = i;
    kr = r;
    kmask = cm;
    down = 1'b1;
    drive_col();
    to_sample(r);
    repeat (DB - 1) begin
      step();
      chk("debounce", r, 1'b0);
    end
    ld_next = 1'b1;
    ld_code = r * COLS + c;
    ack = (ackd == 0);
    step();
    ack = 1'b0;
    chk("load", r, 1'b1);
    since = 0;
    for (int i = 1; i <= hold; i++) begin
      logic rep;
      rep = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep = (i == DLY) || (i > DLY && (i - DLY) % RATE == 0);
`endif
      since++;
      ld_next = rep;
      ack = rep ? (ackd == 0) : (ackd > 0 && since == ackd);
      step();
      ack = 1'b0;
      if (rep) since = 0;
      chk("held", r, 1'b1);
    end
    down = 1'b0;
    col = '0;
    if (do_rst) begin
      #2 rst = 1'b1;
      #1;
      m_valid = 1'b0;
      m_ovr = 1'b0;
      m_code = 0;
      base_ec = ec;
      base_row = 0;
      chk("rst_async", 0, 1'b0);
      step();
      chk("rst_hold", 0, 1'b0);
      rst = 1'b0;
      base_ec = ec;
      chk("rst_rel", 0, 1'b0);
    end else begin
      repeat (DB - 1) begin
        step();
        chk("release", r, 1'b1);
      end
      step();
      base_ec = ec;
      base_row = (r + 1) % ROWS;
      chk("resume", base_row, 1'b0);
    end
  endtask

  task automatic bounce(int r, logic [COLS-1:0] cm, int b);
    kr = r;
    kmask = cm;
    down = 1'b1;
    drive_col();
    to_sample(r);
    repeat (b) begin
      step();
      chk("bounce", r, 1'b0);
    end
    down = 1'b0;
    col = '0;
    step();
    base_ec = ec;
    base_row = (r + 1) % ROWS;
    chk("bounce_exit", base_row, 1'b0);
  endtask

  initial begin
    int r;
    int ad;
    logic [COLS-1:0] cm;

    #2 rst = 1'b1;
    #2;
    chk("reset", 0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ec = 0;
    base_ec = 0;
    base_row = 0;
    chk("reset_rel", 0, 1'b0);

    idle(2 * ROWS * SD + 4);
    press_key(2, 3'b010, 31, -1, 1'b0);
    bounce(1, 3'b010, 4);
    press_key(3, 3'b100, 5, -1, 1'b0);
    press_key(3, 3'b100, 5, 0, 1'b0);
    ack_pulse();
    ack_pulse();
    idle(3);
    press_key(0, 3'b101, 10, 3, 1'b0);
    idle(5);
    press_key(1, 3'b001, 120, 3, 1'b0);
    idle(5);

    for (int k = 0; k < 12; k++) begin
      r = int'($urandom_range(ROWS - 1, 0));
      cm = COLS'($urandom_range((1 << COLS) - 1, 1));
      ad = int'($urandom_range(6, 0)) - 1;
      if ($urandom_range(3, 0) == 0)
        bounce(r, cm, int'($urandom_range(DB - 1, 0)));
      else
        press_key(r, cm, int'($urandom_range(40, 0)), ad, 1'b0);
      idle(int'($urandom_range(10, 0)));
      if ($urandom_range(1, 0) == 1) ack_pulse();
    end

    press_key(2, 3'b001, 20, -1, 1'b1);
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
